// File: rtl/seg7_pkg.sv
// Shared constants for the 4-digit multiplexed 7-segment driver.
// All glyphs are active-low, ordered {g,f,e,d,c,b,a}.
package seg7_pkg;

  typedef logic [1:0] dig_t;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [3:0] AN_OFF    = 4'hF;

endpackage

// File: rtl/seg7_decode.sv
// Nibble to active-low 7-segment glyph; non-decimal nibbles show a dash.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [6:0] o_glyph
);

  always_comb begin
    o_glyph = SEG_DASH;
    case (i_nibble)
      4'd0: o_glyph = SEG_0;
      4'd1: o_glyph = SEG_1;
      4'd2: o_glyph = SEG_2;
      4'd3: o_glyph = SEG_3;
      4'd4: o_glyph = SEG_4;
      4'd5: o_glyph = SEG_5;
      4'd6: o_glyph = SEG_6;
      4'd7: o_glyph = SEG_7;
      4'd8: o_glyph = SEG_8;
      4'd9: o_glyph = SEG_9;
      default: o_glyph = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg7_scan4.sv
// Four-digit time-multiplexed display driver: captures a packed BCD word on load
// and scans it onto shared segment lines with leading-zero blanking and decimal points.
module seg7_scan4
  import seg7_pkg::*;
#(
  parameter int TICKS_PER_DIGIT = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] bcd_in,
  input  logic        load,
  input  logic [3:0]  dp_in,
  input  logic        lzb_en,
  input  logic        en,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an
);

  localparam int TW = (TICKS_PER_DIGIT > 2) ? $clog2(TICKS_PER_DIGIT) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICKS_PER_DIGIT - 1);

  logic [TW-1:0] r_tick_cnt;
  dig_t          r_dig;
  logic [15:0]   r_bcd_q;
  logic [3:0]    r_dp_q;

  logic [3:0]    w_nibble;
  logic          w_blank;
  logic [6:0]    w_glyph;

  // Display data is taken only from the captured copy so a scan never tears.
  always_comb begin
    w_nibble = r_bcd_q[3:0];
    w_blank  = 1'b0;
    case (r_dig)
      2'd0: begin
        w_nibble = r_bcd_q[3:0];
        w_blank  = 1'b0;
      end
      2'd1: begin
        w_nibble = r_bcd_q[7:4];
        w_blank  = (r_bcd_q[15:4] == 12'h000);
      end
      2'd2: begin
        w_nibble = r_bcd_q[11:8];
        w_blank  = (r_bcd_q[15:8] == 8'h00);
      end
      default: begin
        w_nibble = r_bcd_q[15:12];
        w_blank  = (r_bcd_q[15:12] == 4'h0);
      end
    endcase
  end

  seg7_decode u_decode (
    .i_nibble (w_nibble),
    .o_glyph  (w_glyph)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tick_cnt <= '0;
      r_dig      <= '0;
      r_bcd_q    <= '0;
      r_dp_q     <= '0;
      seg        <= SEG_BLANK;
      dp         <= 1'b1;
      an         <= AN_OFF;
    end else begin
      if (r_tick_cnt == TICK_LAST) begin
        r_tick_cnt <= '0;
        r_dig      <= r_dig + 2'd1;
      end else begin
        r_tick_cnt <= r_tick_cnt + 1'b1;
      end

      if (load) begin
        r_bcd_q <= bcd_in;
        r_dp_q  <= dp_in;
      end

      // Outputs are still computed while disabled; only the anodes are forced off.
      seg <= (lzb_en && w_blank) ? SEG_BLANK : w_glyph;
      dp  <= ~r_dp_q[r_dig];
      an  <= en ? ~(4'b0001 << r_dig) : AN_OFF;
    end
  end

endmodule
